cake_stack_drawer: RTL

- Reader end of the catch-colour log. Accepts caught-cake colours from the catch path and stores them in order.
- On request, reads the log back and emits one pixel draw request per pixel. Each logged cake is drawn as a BLOCK_W x BLOCK_H layer, stacked upward from a base point.
- Feeds the VGA plotting datapath through a valid/ready handshake, so the caught stack can be shown on the end screen.

---
 rtl/cake_stack_drawer_if.sv | 19 +
 rtl/cake_stack_drawer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cake_stack_drawer_if.sv
// Pixel draw bus between the stack drawer and the VGA plotting datapath.
// The drawer is the master: it offers a pixel, the plotter answers with draw_ready.
interface cake_stack_drawer_if;
    logic       draw_valid;
    logic       draw_ready;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_clr;

    modport master (
        output draw_valid, draw_x, draw_y, draw_clr,
        input  draw_ready
    );

    modport slave (
        input  draw_valid, draw_x, draw_y, draw_clr,
        output draw_ready
    );
endinterface

// File: rtl/cake_stack_drawer.sv
// Catch-colour log plus playback engine that draws the caught cakes as a stacked column.
// Optional macro STACK_FROSTING_EN: top row of every layer is drawn white (3'b111).
module cake_stack_drawer #(
    parameter int         DEPTH   = 16,
    parameter int         BLOCK_W = 8,
    parameter int         BLOCK_H = 2,
    parameter logic [7:0] BASE_X  = 8'd4,
    parameter logic [6:0] BASE_Y  = 7'd116
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       log_we,
    input  logic [2:0]                 log_clr,
    input  logic                       clear,
    input  logic                       start,
    cake_stack_drawer_if.master        draw,
    output logic                       busy,
    output logic                       done,
    output logic [4:0]                 count,
    output logic                       log_full
);
    localparam int AW = (DEPTH   > 1) ? $clog2(DEPTH)   : 1;
    localparam int CW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int RW = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAW, FINISH} state_t;

    state_t        state, state_next;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [4:0]    n_snap;
    logic [4:0]    layer;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [2:0]    blk_clr;
    logic [2:0]    pix_clr;
    logic [6:0]    y_off;
    logic          clr_en, wr_en, fire;
    logic          col_last, row_last, layer_last;

    // clear is honoured only when idle and then beats a simultaneous write
    assign clr_en     = clear && (state == IDLE);
    assign wr_en      = log_we && !log_full && (log_clr != 3'b000) && !clr_en;
    assign log_full   = (count == 5'(DEPTH));
    assign fire       = (state == DRAW) && draw.draw_ready;
    assign col_last   = (col == CW'(BLOCK_W - 1));
    assign row_last   = (row == RW'(BLOCK_H - 1));
    assign layer_last = ((layer + 5'd1) == n_snap);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr_en) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 5'd1;
        end
    end

    // NOTE: the colour array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= log_clr;
        end
        if (state == FETCH) begin
            blk_clr <= mem[layer[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == 5'd0) ? FINISH : FETCH;
                end
            end
            FETCH:  state_next = DRAW;
            DRAW: begin
                if (fire && col_last && row_last) begin
                    state_next = layer_last ? FINISH : FETCH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_snap <= '0;
            layer  <= '0;
            col    <= '0;
            row    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state == FINISH);
            if (state == IDLE && start) begin
                n_snap <= count;
                layer  <= '0;
            end
            if (state == FETCH) begin
                col <= '0;
                row <= '0;
            end
            if (fire) begin
                if (!col_last) begin
                    col <= col + 1'b1;
                end else begin
                    col <= '0;
                    if (!row_last) begin
                        row <= row + 1'b1;
                    end else begin
                        row   <= '0;
                        layer <= layer + 5'd1;
                    end
                end
            end
        end
    end

    // layers grow upward, so y counts down from the base row and wraps at 7 bits
    assign y_off = 7'(32'(layer) * BLOCK_H + 32'(row));

`ifdef STACK_FROSTING_EN
    assign pix_clr = row_last ? 3'b111 : blk_clr;
`else
    assign pix_clr = blk_clr;
`endif

    assign draw.draw_valid = (state == DRAW);
    assign draw.draw_x     = draw.draw_valid ? (BASE_X + 8'(col)) : 8'd0;
    assign draw.draw_y     = draw.draw_valid ? (BASE_Y - y_off)   : 7'd0;
    assign draw.draw_clr   = draw.draw_valid ? pix_clr            : 3'd0;
endmodule
